sum_uart_tx: RTL and testbench
==============================

Name: sum_uart_tx

Overview:
- Serial transmit end for the operand-sum datapath.
- Accepts an operand pair over a valid/ready handshake, forms the 8-bit sum plus carry, and sends the sum LSB-first as an 8N1 UART frame on one output pin.
- Sits behind the dedicated input pins in a tt_um top. tx drives uo_out[0]; busy and carry_flag drive spare uo_out bits.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  8  operand A.
- b_in  input  8  operand B.
- valid_in  input  1  operand pair valid.
- ready_out  output  1  block can accept a pair this cycle.
- tx  output  1  UART serial line; idle high.
- busy  output  1  frame in progress.
- carry_flag  output  1  carry out of the last accepted sum.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting rst immediately forces:
  - state=IDLE, tx=1, busy=0, ready_out=1, carry_flag=0.
  - baud counter=0, bit index=0, shift register=0.
  - A frame in flight when rst asserts is abandoned, with no glitch on tx other than the forced 1.
- Handshake:
  - A pair is accepted on a rising edge where valid_in=1 and ready_out=1.
  - ready_out=1 only in IDLE, so it is registered with no combinational path from valid_in.
- Sum arithmetic: on accept, {carry, sum[7:0]} = a_in + b_in, 9-bit unsigned, no saturation. sum is loaded into the shift register and carry_flag is updated; carry_flag holds until the next accept.
- FSM states: IDLE, START, DATA, STOP (PARITY added by the optional feature).
- IDLE:
  - tx=1, busy=0.
  - On accept go to START; ready_out and busy change in the same cycle as the state change.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index=0.
- DATA:
  - tx=shift_reg[0] for CLKS_PER_BIT cycles.
  - Then shift right. If bit index=7, go to STOP; otherwise increment the index.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the FSM.
  - Cleared on every state entry.
- Latency: tx falls on the first clk edge after the accepting edge. Frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back transfers: ready_out returns to 1 on the cycle IDLE is re-entered. A valid_in held high is accepted on that same edge, giving a minimum gap of 0 idle bit-times beyond the stop bit.
- valid_in during START/DATA/STOP is ignored; operands are not captured, and the upstream must hold them.
- a_in and b_in are sampled only at accept; later changes do not affect the frame.
- tx, busy and ready_out are registered outputs.

Optional Feature:
- Macro: SUM_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of sum[7:0]) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles (8E1).
- Undefined: no PARITY state and no parity logic; frame is 8N1, 10 bit-times.

Test Plan:
- Reset mid-frame: CLKS_PER_BIT=4; accept a=0x0F, b=0x01, then pulse rst during DATA bit 3 -> tx=1, busy=0, ready_out=1, carry_flag=0 within the same cycle; the next accept starts a clean frame.
- Basic frame: CLKS_PER_BIT=4, a=0x12, b=0x34 -> sum 0x46, carry_flag=0.
  - tx: start 0, then bits 0,1,1,0,0,0,1,0 (LSB first), then stop 1; each held 4 cycles, 40 cycles total.
  - busy high for 40 cycles.
- Carry/wrap: a=0xFF, b=0x02 -> transmitted byte 0x01, carry_flag=1 from the cycle after accept.
  - A following a=0x01, b=0x01 clears carry_flag=0 at its accept.
- Busy rejection: hold valid_in=1 with a=0xAA, b=0x00 for the whole frame, changing operands mid-frame to 0x55 -> exactly one frame per IDLE entry.
  - The first frame carries 0xAA.
  - The second accept occurs on the IDLE re-entry cycle with the operands present then.
- Parity (SUM_UART_PARITY_EN defined): a=0x03, b=0x04 -> 0x07, parity bit 1, 44-cycle frame at CLKS_PER_BIT=4. Undefined: same stimulus gives a 40-cycle frame.
- Baud extremes: CLKS_PER_BIT=2 and CLKS_PER_BIT=1000 -> bit cell widths exactly 2 and 1000 cycles, no counter overflow.

Source files
------------

// File: rtl/sum_uart_tx.sv
// Operand-sum UART transmitter: accepts {a,b}, sends (a+b)[7:0] LSB-first as 8N1.
// Define SUM_UART_PARITY_EN to insert an even-parity bit (8E1).
module sum_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       carry_flag
);

`ifdef SUM_UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             carry_q, carry_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
`ifdef SUM_UART_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [8:0] sum_c;
    logic       bit_done_c;

    assign sum_c      = 9'(a_in) + 9'(b_in);
    assign bit_done_c = (cnt_q == CNT_MAX);

    // Next-state and output logic; tx is registered from the current state so it
    // trails the state by one clock and falls on the edge after the accept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        tx_d     = 1'b1;
`ifdef SUM_UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (valid_in && ready_q) begin
                    state_d  = S_START;
                    shift_d  = sum_c[7:0];
                    carry_d  = sum_c[8];
                    idx_d    = 3'd0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
`ifdef SUM_UART_PARITY_EN
                    parity_d = ^sum_c[7:0];
`endif
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_done_c) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_done_c) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SUM_UART_PARITY_EN
            S_PARITY: begin
                tx_d = parity_q;
                if (bit_done_c) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_done_c) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            carry_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef SUM_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            carry_q  <= carry_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
`ifdef SUM_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign ready_out  = ready_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Randomized self-checking bench for sum_uart_tx at three baud divisors (4, 2, 1000).
module tb_sum_uart_tx;

`ifdef SUM_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       valid;
    logic [2:0] tx_w, busy_w, ready_w, carry_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .a_in(a), .b_in(b), .valid_in(valid),
        .ready_out(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .carry_flag(carry_w[0]));
    sum_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .a_in(a), .b_in(b), .valid_in(valid),
        .ready_out(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .carry_flag(carry_w[1]));
    sum_uart_tx #(.CLKS_PER_BIT(1000), .CNT_W(16)) u_dut1000 (
        .clk(clk), .rst(rst), .a_in(a), .b_in(b), .valid_in(valid),
        .ready_out(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .carry_flag(carry_w[2]));

    function automatic int cpb_of(input int sel);
        if (sel == 0) return 4;
        if (sel == 1) return 2;
        return 1000;
    endfunction

    // Bounded wait (at negedges) for the selected instance to offer ready.
    task automatic wait_ready(input int sel);
        int n = 0;
        while (ready_w[sel] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout dut%0d got %b want 1", sel, ready_w[sel]);
        end
    endtask

    // Send one pair and check the whole serial frame against the expected bit list.
    task automatic do_frame(input int sel, input logic [7:0] av, input logic [7:0] bv,
                            input bit hold, input bit chg, input logic [7:0] ca,
                            input logic [7:0] cb, input string tag);
        int          cpb;
        logic [8:0]  tot;
        logic [10:0] frame;
        logic        exp_tx, exp_busy;
        cpb   = cpb_of(sel);
        tot   = {1'b0, av} + {1'b0, bv};
        frame = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[i+1] = tot[i];
`ifdef SUM_UART_PARITY_EN
        frame[9] = ^tot[7:0];
`endif
        wait_ready(sel);
        a = av; b = bv; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
        end
        checks++;
        if (busy_w[sel] !== 1'b1 || ready_w[sel] !== 1'b0 || tx_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s accept dut%0d busy/ready/tx got %b%b%b want 101",
                     tag, sel, busy_w[sel], ready_w[sel], tx_w[sel]);
        end
        checks++;
        if (carry_w[sel] !== tot[8]) begin
            errors++;
            $display("FAIL %s carry dut%0d got %b want %b", tag, sel, carry_w[sel], tot[8]);
        end
        for (int j = 1; j <= NB * cpb; j++) begin
            @(negedge clk);
            if (chg && j == cpb * 3) begin
                a = ca; b = cb;
            end
            exp_tx   = frame[(j - 1) / cpb];
            exp_busy = (j < NB * cpb);
            checks++;
            if (tx_w[sel] !== exp_tx) begin
                errors++;
                $display("FAIL %s tx dut%0d cyc %0d got %b want %b", tag, sel, j, tx_w[sel], exp_tx);
            end
            checks++;
            if (busy_w[sel] !== exp_busy) begin
                errors++;
                $display("FAIL %s busy dut%0d cyc %0d got %b want %b", tag, sel, j, busy_w[sel], exp_busy);
            end
        end
        checks++;
        if (ready_w[sel] !== 1'b1 || carry_w[sel] !== tot[8]) begin
            errors++;
            $display("FAIL %s end dut%0d ready/carry got %b%b want 1%b",
                     tag, sel, ready_w[sel], carry_w[sel], tot[8]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; a = 8'd0; b = 8'd0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({tx_w[s], busy_w[s], ready_w[s], carry_w[s]} !== 4'b1010) begin
                errors++;
                $display("FAIL reset dut%0d tx/busy/ready/carry got %b%b%b%b want 1010",
                         s, tx_w[s], busy_w[s], ready_w[s], carry_w[s]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_frame(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 8'h00, "basic");
    endtask

    task automatic test_carry();
        do_frame(0, 8'hFF, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, "carry_set");
        do_frame(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, "carry_clr");
    endtask

    task automatic test_back_to_back();
        do_frame(0, 8'hAA, 8'h00, 1'b1, 1'b1, 8'h55, 8'h00, "b2b_first");
        do_frame(0, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "b2b_second");
    endtask

    task automatic test_parity();
        do_frame(0, 8'h03, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, "parity");
    endtask

    task automatic test_reset_mid_frame();
        do_frame(0, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, "pre_rst_carry");
        wait_ready(0);
        a = 8'h0F; b = 8'h01; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (17) @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre tx/busy got %b%b want 01", tx_w[0], busy_w[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_w[0], busy_w[0], ready_w[0], carry_w[0]} !== 4'b1010) begin
            errors++;
            $display("FAIL rst_mid async tx/busy/ready/carry got %b%b%b%b want 1010",
                     tx_w[0], busy_w[0], ready_w[0], carry_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_frame(0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, "rst_mid_clean");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++)
            do_frame(0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00, "rand4");
        for (int k = 0; k < 4; k++)
            do_frame(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00, "rand2");
    endtask

    task automatic test_baud_extremes();
        do_frame(1, 8'hFE, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, "baud2");
        do_frame(2, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00, "baud1000");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_random();
        test_baud_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
